// File: rtl/umem_arb_pkg.sv
// Shared types and helpers for the umem arbiter: access size encoding,
// sequencer state encoding and the request legality check.
package umem_arb_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // A request is rejected when its size code is illegal or the byte address
  // is not naturally aligned to the access size.
  function automatic logic is_bad_req(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = addr_lo[0];
      SZ_W:    bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/umem_lane_align.sv
// Combinational lane steering between a right-aligned requester view and the
// 32-bit umem word: write strobes, replicated write data and read extraction.
module umem_lane_align
  import umem_arb_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [31:0] rdata_shift;
  logic [3:0]  keep_mask;

  // Strobes, replication and the byte-keep mask all follow from the size code.
  always_comb begin
    wstrb     = 4'b0000;
    wdata_rep = wdata;
    keep_mask = 4'b0000;
    case (size)
      SZ_B: begin
        wstrb     = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        keep_mask = 4'b0001;
      end
      SZ_H: begin
        wstrb     = 4'b0011 << addr_lo;
        wdata_rep = {2{wdata[15:0]}};
        keep_mask = 4'b0011;
      end
      SZ_W: begin
        wstrb     = 4'b1111;
        wdata_rep = wdata;
        keep_mask = 4'b1111;
      end
      default: ;
    endcase
  end

  assign rdata_shift = mem_rdata >> {addr_lo, 3'b000};

  // Zero every byte above the access size; sign extension is left to the requester.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign rdata_ext[8*gi +: 8] = keep_mask[gi] ? rdata_shift[8*gi +: 8] : 8'h00;
    end
  endgenerate

endmodule

// File: rtl/umem_arbiter.sv
// Two-requester round-robin arbiter and fixed-latency access sequencer for
// the single umem port. One transaction in flight at a time.
module umem_arbiter
  import umem_arb_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_rw,
  input  logic [1:0]        req0_size,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [31:0]       req0_wdata,
  output logic              rsp0_valid,
  output logic [31:0]       rsp0_rdata,
  output logic              rsp0_err,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_rw,
  input  logic [1:0]        req1_size,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [31:0]       req1_wdata,
  output logic              rsp1_valid,
  output logic [31:0]       rsp1_rdata,
  output logic              rsp1_err,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  state_e            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              last_grant_reg;
  logic              owner_reg;
  logic              rw_reg;
  logic [1:0]        size_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic              rsp0_valid_reg;
  logic              rsp1_valid_reg;
  logic              rsp_err_reg;
  logic [31:0]       rsp_rdata_reg;

  logic              grant0;
  logic              grant1;
  logic              sel_rw;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic              sel_bad;
  logic [3:0]        lane_wstrb;
  logic [31:0]       lane_wdata;
  logic [31:0]       lane_rdata;
  logic              mem_wr;

  // On a tie the requester that was not served last wins.
  assign grant0 = (state_reg == ST_IDLE) & req0_valid & (~req1_valid | last_grant_reg);
  assign grant1 = (state_reg == ST_IDLE) & req1_valid & (~req0_valid | ~last_grant_reg);

  assign sel_rw    = grant1 ? req1_rw    : req0_rw;
  assign sel_size  = grant1 ? req1_size  : req0_size;
  assign sel_addr  = grant1 ? req1_addr  : req0_addr;
  assign sel_wdata = grant1 ? req1_wdata : req0_wdata;
  assign sel_bad   = is_bad_req(sel_size, sel_addr[1:0]);

  umem_lane_align u_align (
    .size      (size_reg),
    .addr_lo   (addr_reg[1:0]),
    .wdata     (wdata_reg),
    .mem_rdata (mem_rdata),
    .wstrb     (lane_wstrb),
    .wdata_rep (lane_wdata),
    .rdata_ext (lane_rdata)
  );

  // Sequencer: latch on handshake, strobe memory, wait out the latency, respond.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      rw_reg         <= 1'b0;
      size_reg       <= 2'b00;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      rsp0_valid_reg <= 1'b0;
      rsp1_valid_reg <= 1'b0;
      rsp_err_reg    <= 1'b0;
      rsp_rdata_reg  <= '0;
    end else begin
      rsp0_valid_reg <= 1'b0;
      rsp1_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (grant0 | grant1) begin
            owner_reg      <= grant1;
            last_grant_reg <= grant1;
            rw_reg         <= sel_rw;
            size_reg       <= sel_size;
            addr_reg       <= sel_addr;
            wdata_reg      <= sel_wdata;
            rsp_err_reg    <= sel_bad;
            rsp_rdata_reg  <= '0;
            if (sel_bad) begin
              state_reg      <= ST_RESP;
              rsp0_valid_reg <= ~grant1;
              rsp1_valid_reg <= grant1;
            end else begin
              state_reg <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (MEM_LAT > 1) begin
            state_reg <= ST_WAIT;
            cnt_reg   <= CNT_W'(1);
          end else begin
            state_reg      <= ST_RESP;
            rsp_rdata_reg  <= rw_reg ? 32'h0 : lane_rdata;
            rsp0_valid_reg <= ~owner_reg;
            rsp1_valid_reg <= owner_reg;
          end
        end
        ST_WAIT: begin
          if (cnt_reg == CNT_LAST) begin
            state_reg      <= ST_RESP;
            cnt_reg        <= '0;
            rsp_rdata_reg  <= rw_reg ? 32'h0 : lane_rdata;
            rsp0_valid_reg <= ~owner_reg;
            rsp1_valid_reg <= owner_reg;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Memory-side outputs are decoded from registered state, so they clear as
  // soon as reset forces the FSM back to IDLE.
  assign mem_en    = (state_reg == ST_ACCESS);
  assign mem_wr    = mem_en & rw_reg;
  assign mem_rw    = mem_wr;
  assign mem_addr  = mem_en ? {addr_reg[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata = mem_wr ? lane_wdata : 32'h0;
  assign mem_wstrb = mem_wr ? lane_wstrb : 4'b0000;

  assign rsp0_valid = rsp0_valid_reg;
  assign rsp1_valid = rsp1_valid_reg;
  assign rsp0_err   = rsp0_valid_reg & rsp_err_reg;
  assign rsp1_err   = rsp1_valid_reg & rsp_err_reg;
  assign rsp0_rdata = rsp0_valid_reg ? rsp_rdata_reg : 32'h0;
  assign rsp1_rdata = rsp1_valid_reg ? rsp_rdata_reg : 32'h0;

endmodule

// File: doc/umem_arbiter.md
# umem_arbiter

Two-port arbiter and access sequencer for the unified data memory (umem). It shares the single umem port between requester 0 (CPU load/store path) and requester 1 (program loader/debug port). Each accepted request runs as a multi-cycle transaction: lane alignment, byte strobes, fixed-latency wait, then a one-cycle response. Round-robin arbitration guarantees neither requester starves.

## Interface
- MEM_LAT, 1: umem read latency in cycles (≥1), counted from the mem_en cycle.
- ADDR_W, 32: byte-address width.
- clk  in  1  system clock, all state on rising edge.
- nreset  in  1  reset, asynchronous assert, active-low.
- reqN_valid  in  1  request N (N=0,1) pending; held until accepted.
- reqN_ready  out  1  request N accepted this cycle (valid & ready = handshake).
- reqN_rw  in  1  1=write, 0=read.
- reqN_size  in  2  0=byte, 1=half, 2=word; 3=illegal.
- reqN_addr  in  ADDR_W  byte address.
- reqN_wdata  in  32  write data, right-aligned.
- rspN_valid  out  1  one-cycle response pulse for requester N.
- rspN_rdata  out  32  read data shifted to bit 0, unused upper bits zero; 0 on write/error.
- rspN_err  out  1  misaligned or illegal-size request; qualified by rspN_valid.
- mem_en  out  1  umem access strobe, high exactly one cycle per access.
- mem_rw  out  1  1=write.
- mem_addr  out  ADDR_W  word-aligned address (addr[1:0] forced 0).
- mem_wdata  out  32  lane-replicated write data.
- mem_wstrb  out  4  byte-lane write enables; 0 on reads.
- mem_rdata  in  32  umem read word.

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE: winner's reqN_ready=1 combinationally when its valid=1; loser's ready=0. Handshake latches rw/size/addr/wdata/owner. The next state is ACCESS, or RESP if the request is an error.
- Arbitration: single requester wins. If both are valid, the winner is the requester not granted last (last_grant register). After reset, last_grant=1, so requester 0 wins the first tie.
- Error: size=3, half with addr[0]=1, or word with addr[1:0]≠0. An error request makes no memory access; rsp_err=1, rdata=0.
- ACCESS: mem_en=1 for one cycle with mem_rw, mem_addr, mem_wdata, mem_wstrb. Next state is WAIT if MEM_LAT>1, else RESP.
- WAIT: counter counts MEM_LAT-1 cycles, then the FSM moves to RESP. At the edge entering RESP, the owner's read data is registered from mem_rdata.
- Writes still traverse WAIT. Response is an ack with rdata=0.
- Write lanes:
  - byte: wdata {4{wdata[7:0]}}, wstrb 4'b0001<<addr[1:0].
  - half: wdata {2{wdata[15:0]}}, wstrb 4'b0011<<addr[1:0].
  - word: wdata passed through, wstrb 4'b1111.
- Read extract: rdata = mem_rdata >> (8*addr[1:0]), then zero-masked to the access size. Sign extension is the requester's job.
- RESP: owner's rsp_valid=1 for one cycle, then IDLE. No ready is asserted in RESP.

## Timing
- Handshake in cycle T. mem_en high in T+1. mem_rdata valid in T+MEM_LAT. rsp_valid high in T+MEM_LAT+1.
- Error handshake in T gives rsp_valid+err in T+1.
- Throughput: one transaction per MEM_LAT+2 cycles. Earliest re-handshake is the cycle after RESP.
- Reset values: all outputs 0, state IDLE, counter 0, last_grant 1.
- Reset mid-transaction drops the in-flight access: no rsp_valid, and mem_en drops asynchronously.
- A requester deasserting valid before ready is tolerated. Nothing is latched.

## Structure
- Package umem_arb_pkg holds:
  - size enum (SZ_B, SZ_H, SZ_W).
  - FSM state enum.
  - the misalignment check function.
- Sub-module umem_lane_align (combinational) produces wstrb, replicated wdata and extracted rdata from size, addr[1:0], wdata and mem_rdata.
- The top holds the FSM, latency counter, round-robin register and response registers.

## Test plan
- MEM_LAT=1, req0 read word addr 0x10, mem returns 0xDEADBEEF → mem_en at T+1 with mem_addr 0x10, rsp0_valid at T+2 with rdata 0xDEADBEEF.
- req1 write byte 0xA5 at addr 0x13 → mem_wstrb 4'b1000, mem_wdata 0xA5A5A5A5; rsp1_valid ack with rdata 0.
- Both valid continuously for 4 transactions after reset → grant order 0,1,0,1, with no back-to-back grant to one requester.
- req0 half read at addr 0x21 → no mem_en, rsp0_valid at T+1 with err=1; size=3 also gives err.
- MEM_LAT=3, half read addr 0x22, mem_rdata 0x12345678 → rsp at T+4 with rdata 0x00001234.
- nreset low during WAIT → outputs 0 immediately, no response; the next request after release is served normally.
